// File: rtl/acc_pkg.sv
// Shared types and defaults for the channel accumulator slice.
// Saturation is selected by the ACC_SAT_EN macro in acc_add_sat.
package acc_pkg;

  localparam int PROD_W  = 32;
  localparam int ACC_W   = 48;
  localparam int SCALE_W = 24;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } acc_state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W signed adder with overflow detect.
// ACC_SAT_EN defined: clamp on overflow; undefined: two's-complement wrap.
module acc_add_sat #(
  parameter int ACC_W = acc_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  localparam logic signed [ACC_W-1:0] L_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] L_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] w_wide;

  // One guard bit: the sum left the ACC_W range exactly when the top two bits differ.
  function automatic logic signed [ACC_W-1:0] resolve(input logic signed [ACC_W:0] s);
`ifdef ACC_SAT_EN
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? L_MIN : L_MAX;
    return s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign w_wide = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
  assign o_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  assign o_sum  = resolve(w_wide);

endmodule

// File: rtl/channel_accumulator.sv
// Per-channel bias-seeded accumulator feeding the requantizer (data_in/scale).
// Build option ACC_SAT_EN selects saturating instead of wrapping accumulation.
module channel_accumulator #(
  parameter int PROD_W  = acc_pkg::PROD_W,
  parameter int ACC_W   = acc_pkg::ACC_W,
  parameter int SCALE_W = acc_pkg::SCALE_W,
  parameter int BIAS_W  = 32,
  parameter int NUM_CH  = 16,
  parameter int CH_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [PROD_W-1:0]  in_prod,
  input  logic        [CH_W-1:0]    in_ch,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      cfg_we,
  input  logic        [CH_W-1:0]    cfg_ch,
  input  logic signed [BIAS_W-1:0]  cfg_bias,
  input  logic signed [SCALE_W-1:0] cfg_scale,
  output logic                      out_valid,
  output logic signed [ACC_W-1:0]   out_acc,
  output logic signed [SCALE_W-1:0] out_scale,
  output logic        [CH_W-1:0]    out_ch,
  output logic                      ovf
);

  import acc_pkg::*;

  acc_state_t                r_state;
  logic [CH_W-1:0]           r_cnt;
  logic                      r_ovf;
  logic signed [ACC_W-1:0]   r_acc   [NUM_CH];
  logic signed [BIAS_W-1:0]  r_bias  [NUM_CH];
  logic signed [SCALE_W-1:0] r_scale [NUM_CH];

  logic                      r_vld_p1;
  logic signed [ACC_W-1:0]   r_acc_p1;
  logic signed [SCALE_W-1:0] r_scale_p1;
  logic [CH_W-1:0]           r_ch_p1;

  logic                      w_run;
  logic                      w_accept;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_ovf;

  // A clear pulse wins over a beat presented in the same cycle.
  assign w_run      = (r_state == RUN);
  assign w_accept   = in_valid & w_run & ~clear;
  assign w_bias_ext = {{(ACC_W-BIAS_W){r_bias[in_ch][BIAS_W-1]}}, r_bias[in_ch]};
  assign w_prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign w_base     = in_first ? w_bias_ext : r_acc[in_ch];

  acc_add_sat #(.ACC_W(ACC_W)) u_add (
    .i_a   (w_base),
    .i_b   (w_prod_ext),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Stage p0 -> p1: control, tables and the registered result port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_acc_p1   <= '0;
      r_scale_p1 <= '0;
      r_ch_p1    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_bias[k]  <= '0;
        r_scale[k] <= '0;
      end
    end else begin
      if (clear) begin
        r_state <= CLEAR;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CH_W'(NUM_CH-1)) r_state <= RUN;
      end else if (w_accept && w_ovf) begin
        r_ovf <= 1'b1;
      end

      r_vld_p1 <= w_accept & in_last;
      if (w_accept && in_last) begin
        r_acc_p1   <= w_sum;
        r_scale_p1 <= r_scale[in_ch];
        r_ch_p1    <= in_ch;
      end

      // Reads above see the pre-write table contents on a same-cycle update.
      if (cfg_we) begin
        r_bias[cfg_ch]  <= cfg_bias;
        r_scale[cfg_ch] <= cfg_scale;
      end
    end
  end

  // Accumulator array: zeroed by the sweep and after each emitted window.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_acc[r_cnt] <= '0;
    end else if (w_accept) begin
      r_acc[in_ch] <= in_last ? '0 : w_sum;
    end
  end

  assign in_ready  = w_run;
  assign out_valid = r_vld_p1;
  assign out_acc   = r_acc_p1;
  assign out_scale = r_scale_p1;
  assign out_ch    = r_ch_p1;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_channel_accumulator.sv
// Directed bench for channel_accumulator: behavioural model checked every cycle
// plus literal expectations for the documented scenarios.
module tb_channel_accumulator;

  localparam int     NCH   = 16;
  localparam longint MAXV  = (64'sd1 <<< 47) - 1;
  localparam longint MINV  = -(64'sd1 <<< 47);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_prod = '0;
  logic [3:0]         in_ch = '0;
  logic               in_first = 1'b0;
  logic               in_last = 1'b0;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_ch = '0;
  logic signed [31:0] cfg_bias = '0;
  logic signed [23:0] cfg_scale = '0;
  logic               out_valid;
  logic [47:0]        out_acc;
  logic [23:0]        out_scale;
  logic [3:0]         out_ch;
  logic               ovf;

  channel_accumulator dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_ch(in_ch),
    .in_first(in_first), .in_last(in_last),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
    .out_valid(out_valid), .out_acc(out_acc), .out_scale(out_scale), .out_ch(out_ch),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles until ready, per-channel sums, tables, last result.
  int     m_left;
  longint m_acc [NCH];
  longint m_bias [NCH];
  longint m_scale [NCH];
  bit     m_ovf, m_vld;
  longint m_oacc, m_oscale, m_och;

  always @(posedge clk or posedge rst) begin
    longint base, sum, res;
    if (rst) begin
      m_left = NCH; m_ovf = 0; m_vld = 0; m_oacc = 0; m_oscale = 0; m_och = 0;
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0; m_bias[i] = 0; m_scale[i] = 0;
      end
    end else begin
      m_vld = 0;
      if (clear) begin
        m_left = NCH; m_ovf = 0;
        for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (in_valid) begin
        base = in_first ? m_bias[in_ch] : m_acc[in_ch];
        sum  = base + longint'(in_prod);
        res  = sum;
        if (sum > MAXV || sum < MINV) begin
          m_ovf = 1;
`ifdef ACC_SAT_EN
          res = (sum > MAXV) ? MAXV : MINV;
`else
          res = (sum <<< 16) >>> 16;
`endif
        end
        if (in_last) begin
          m_acc[in_ch] = 0;
          m_vld = 1; m_oacc = res; m_oscale = m_scale[in_ch]; m_och = in_ch;
        end else begin
          m_acc[in_ch] = res;
        end
      end
      if (cfg_we) begin
        m_bias[cfg_ch]  = longint'(cfg_bias);
        m_scale[cfg_ch] = longint'(cfg_scale);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  longint'(in_ready), longint'(m_left == 0));
      chk("out_valid", longint'(out_valid), longint'(m_vld));
      chk("out_acc",   longint'($signed(out_acc)), m_oacc);
      chk("out_scale", longint'($signed(out_scale)), m_oscale);
      chk("out_ch",    longint'(out_ch), m_och);
      chk("ovf",       longint'(ovf), longint'(m_ovf));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic beat(input int ch, input longint prod, input bit first, input bit last);
    in_valid = 1'b1; in_ch = 4'(ch); in_prod = 32'(prod);
    in_first = first; in_last = last;
    @(posedge clk); #2;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic cfg(input int ch, input longint bias, input longint scale);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_bias = 32'(bias); cfg_scale = 24'(scale);
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  task automatic wait_ready(output int cycles, output bit saw_pulse);
    cycles = 0; saw_pulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      cycles++;
      if (out_valid) saw_pulse = 1;
      if (in_ready) break;
    end
  endtask

  initial begin
    int  cyc;
    bit  pulse;
    longint ovf_exp;

    idle(3);
    chk_en = 1'b1;
    idle(1);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_acc", longint'(out_acc), 0);
    chk("rst_valid", longint'(out_valid), 0);

    // Reset release: sweep of 16 cycles before accepting beats.
    rst = 1'b0;
    wait_ready(cyc, pulse);
    chk("ready_delay", cyc, 16);

    // Basic window on ch3.
    cfg(3, 100, 'h000100);
    beat(3, 5, 1, 0);
    beat(3, 7, 0, 0);
    beat(3, -2, 0, 1);
    chk("ch3_valid", longint'(out_valid), 1);
    chk("ch3_acc", longint'($signed(out_acc)), 110);
    chk("ch3_scale", longint'(out_scale), 'h100);
    chk("ch3_ch", longint'(out_ch), 3);
    idle(1);
    chk("hold_valid", longint'(out_valid), 0);
    chk("hold_acc", longint'($signed(out_acc)), 110);

    // Interleaved ch0/ch1; back-to-back last beats.
    beat(0, 1, 1, 0);
    beat(1, -4, 1, 0);
    beat(0, 2, 0, 0);
    beat(1, -4, 0, 1);
    chk("ch1_acc", longint'($signed(out_acc)), -8);
    chk("ch1_ch", longint'(out_ch), 1);
    beat(0, 3, 0, 1);
    chk("ch0_valid", longint'(out_valid), 1);
    chk("ch0_acc", longint'($signed(out_acc)), 6);
    chk("ch0_ch", longint'(out_ch), 0);

    // Overflow on ch2.
    cfg(2, 0, 0);
    for (int i = 0; i <= 65536; i++) begin
      beat(2, 'h7FFFFFFF, i == 0, i == 65536);
      if (i == 65535) chk("ovf_before", longint'(ovf), 0);
    end
`ifdef ACC_SAT_EN
    ovf_exp = MAXV;
`else
    ovf_exp = -(64'sd1 <<< 47) + (64'sd1 <<< 31) - 65537;
`endif
    chk("ovf_valid", longint'(out_valid), 1);
    chk("ovf_acc", longint'($signed(out_acc)), ovf_exp);
    chk("ovf_flag", longint'(ovf), 1);

    // Clear mid-window on ch5; the beat alongside clear is dropped.
    cfg(5, 4, 0);
    beat(5, 100, 1, 0);
    clear = 1'b1;
    beat(5, 1, 0, 1);
    clear = 1'b0;
    chk("clr_valid", longint'(out_valid), 0);
    wait_ready(cyc, pulse);
    chk("clr_delay", cyc, 16);
    chk("clr_pulse", longint'(pulse), 0);
    chk("clr_ovf", longint'(ovf), 0);
    beat(5, 9, 1, 1);
    chk("ch5_acc", longint'($signed(out_acc)), 13);

    // Same-cycle table write and beat on ch6: old bias and scale are used.
    cfg_we = 1'b1; cfg_ch = 4'd6; cfg_bias = 32'sd50; cfg_scale = 24'sd7;
    beat(6, 1, 1, 1);
    cfg_we = 1'b0;
    chk("rbw_acc", longint'($signed(out_acc)), 1);
    chk("rbw_scale", longint'(out_scale), 0);
    beat(6, 1, 1, 1);
    chk("new_acc", longint'($signed(out_acc)), 51);
    chk("new_scale", longint'(out_scale), 7);

    // Reset mid-window on ch3 zeroes tables and partial sums.
    beat(3, 1, 1, 0);
    rst = 1'b1;
    idle(2);
    chk("rst2_ready", longint'(in_ready), 0);
    chk("rst2_acc", longint'(out_acc), 0);
    rst = 1'b0;
    wait_ready(cyc, pulse);
    chk("rst2_delay", cyc, 16);
    beat(3, 5, 1, 1);
    chk("rst2_out", longint'($signed(out_acc)), 5);
    chk("rst2_scale", longint'(out_scale), 0);
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
